// File: rtl/br_svc_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : br_svc_buffer_pkg
//  Description : Shared types for the BrLite service receive buffer: the
//                incoming router flit, the stored service entry, the ack
//                phase encoding and the default buffer depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package br_svc_buffer_pkg;

  // Default FIFO depth (entries); must be a power of two, >= 2
  localparam int BR_SVC_BUFFER_SIZE = 8;

  // Flit as delivered by the BrLite router local output port
  typedef struct packed {
    logic [1:0]  service;
    logic [7:0]  ksvc;
    logic [15:0] seq_source;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_flit_t;

  // Entry held in the buffer and presented to the NI (service field dropped)
  typedef struct packed {
    logic [7:0]  ksvc;
    logic [15:0] seq_source;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_svc_t;

  // Router handshake phase: ACK_SENT lasts exactly one cycle after an accept
  typedef enum logic {
    ACK_IDLE = 1'b0,
    ACK_SENT = 1'b1
  } ack_state_t;

  // Strip the routing-only service field from an incoming flit
  function automatic brlite_svc_t flit_to_svc(input brlite_flit_t flit);
    brlite_svc_t svc;
    svc.ksvc       = flit.ksvc;
    svc.seq_source = flit.seq_source;
    svc.producer   = flit.producer;
    svc.payload    = flit.payload;
    return svc;
  endfunction

endpackage : br_svc_buffer_pkg
`default_nettype wire

// File: rtl/br_svc_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : br_svc_buffer
//  Description : Receive-side FIFO for BrLite service flits between the
//                router local port (req/ack) and the DMNI NI (rx/ack pop).
//                Optional statistics (occupancy level and saturating stall
//                counter) are enabled by defining BR_SVC_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module br_svc_buffer
  import br_svc_buffer_pkg::*;
#(
  parameter int BUFFER_SIZE = BR_SVC_BUFFER_SIZE
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       br_req_i,
  output logic                       br_ack_o,
  input  brlite_flit_t               br_data_i,
  output logic                       br_svc_rx_o,
  input  logic                       br_svc_ack_i,
  output brlite_svc_t                br_svc_data_o
`ifdef BR_SVC_STATS_EN
  ,
  output logic [$clog2(BUFFER_SIZE):0] svc_level_o,
  output logic [31:0]                  svc_stall_o
`endif
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BUFFER_SIZE);

  brlite_svc_t      mem [BUFFER_SIZE];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  ack_state_t       ack_state;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // The service field only steers routing upstream and is not stored
  logic service_field_unused;
  assign service_field_unused = ^br_data_i.service;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);

  // Full is evaluated before this cycle's pop, so a push that coincides with
  // a pop on a full buffer is deferred to the following cycle.
  assign push = br_req_i && !full && (ack_state == ACK_IDLE);
  assign pop  = br_svc_ack_i && !empty;

  assign br_svc_rx_o   = !empty;
  assign br_svc_data_o = mem[rd_ptr];

  // Ack phase: one-cycle accept pulse to the router after every push
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_state <= ACK_IDLE;
      br_ack_o  <= 1'b0;
    end else begin
      case (ack_state)
        ACK_IDLE: begin
          if (push) begin
            ack_state <= ACK_SENT;
            br_ack_o  <= 1'b1;
          end
        end
        ACK_SENT: begin
          ack_state <= ACK_IDLE;
          br_ack_o  <= 1'b0;
        end
        default: begin
          ack_state <= ACK_IDLE;
          br_ack_o  <= 1'b0;
        end
      endcase
    end
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= flit_to_svc(br_data_i);
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef BR_SVC_STATS_EN
  assign svc_level_o = count;

  // Count cycles where the router is held off by a full buffer; saturates
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      svc_stall_o <= '0;
    end else if (br_req_i && full && !br_ack_o && (svc_stall_o != 32'hFFFF_FFFF)) begin
      svc_stall_o <= svc_stall_o + 32'd1;
    end
  end
`endif

endmodule : br_svc_buffer
`default_nettype wire

// File: tb/tb_br_svc_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_br_svc_buffer
//  Description : Randomized self-checking bench for br_svc_buffer against a
//                queue-based model of the buffer and its accept handshake.
//                Statistics ports are connected when BR_SVC_STATS_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_br_svc_buffer;
  import br_svc_buffer_pkg::*;

  localparam int BS = BR_SVC_BUFFER_SIZE;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         br_req_i;
  logic         br_ack_o;
  brlite_flit_t br_data_i;
  logic         br_svc_rx_o;
  logic         br_svc_ack_i;
  brlite_svc_t  br_svc_data_o;
`ifdef BR_SVC_STATS_EN
  logic [$clog2(BS):0] svc_level_o;
  logic [31:0]         svc_stall_o;
`endif

  always #5 clk_i = ~clk_i;

  br_svc_buffer #(.BUFFER_SIZE(BS)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .br_req_i      (br_req_i),
    .br_ack_o      (br_ack_o),
    .br_data_i     (br_data_i),
    .br_svc_rx_o   (br_svc_rx_o),
    .br_svc_ack_i  (br_svc_ack_i),
    .br_svc_data_o (br_svc_data_o)
`ifdef BR_SVC_STATS_EN
    ,
    .svc_level_o   (svc_level_o),
    .svc_stall_o   (svc_stall_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: ordered queue of stored entries plus the ack pulse
  brlite_svc_t  mq[$];
  bit           m_ack;
  logic [31:0]  m_stall;

  // Router model state
  bit           have_flit;
  int           seq;
  brlite_flit_t flit;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check("ack", 80'(br_ack_o), 80'(m_ack));
    check("rx", 80'(br_svc_rx_o), 80'(mq.size() != 0));
    if (mq.size() != 0) check("head", 80'(br_svc_data_o), 80'(mq[0]));
`ifdef BR_SVC_STATS_EN
    check("level", 80'(svc_level_o), 80'(mq.size()));
    check("stall", 80'(svc_stall_o), 80'(m_stall));
`endif
  endtask

  // One clock: check outputs, drive router/NI, advance model, move to next negedge
  task automatic step(input int req_pct, input int pop_pct);
    bit full_now;
    bit do_push;
    bit do_pop;
    compare_outputs();
    if (m_ack) have_flit = 1'b0;
    if (!have_flit && (int'($urandom_range(99)) < req_pct)) begin
      seq++;
      flit.service    = 2'($urandom);
      flit.ksvc       = 8'($urandom);
      flit.seq_source = 16'($urandom);
      flit.producer   = 16'($urandom);
      flit.payload    = 32'hCAFE_0000 + 32'(seq);
      if (seq == 1) begin
        flit.ksvc     = 8'h12;
        flit.producer = 16'h0101;
      end
      have_flit = 1'b1;
    end
    br_req_i     = have_flit;
    br_data_i    = flit;
    br_svc_ack_i = (int'($urandom_range(99)) < pop_pct);

    full_now = (mq.size() == BS);
    do_push  = br_req_i && !full_now && !m_ack;
    do_pop   = br_svc_ack_i && (mq.size() != 0);
    if (br_req_i && full_now && !m_ack && (m_stall != 32'hFFFF_FFFF)) m_stall++;
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(flit_to_svc(flit));
    m_ack = do_push;

    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Asynchronous reset from a negedge; outputs must clear immediately
  task automatic reset_dut();
    rst_ni       = 1'b0;
    br_svc_ack_i = 1'b0;
    #1;
    check("rst_rx", 80'(br_svc_rx_o), 80'(0));
    check("rst_ack", 80'(br_ack_o), 80'(0));
`ifdef BR_SVC_STATS_EN
    check("rst_level", 80'(svc_level_o), 80'(0));
    check("rst_stall", 80'(svc_stall_o), 80'(0));
`endif
    mq.delete();
    m_ack   = 1'b0;
    m_stall = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni       = 1'b0;
    br_req_i     = 1'b0;
    br_svc_ack_i = 1'b0;
    br_data_i    = '0;
    flit         = '0;
    have_flit    = 1'b0;
    seq          = 0;
    m_ack        = 1'b0;
    m_stall      = '0;

    @(negedge clk_i);
    reset_dut();

    // Single flit then a second queued behind it
    repeat (4) step(100, 0);
    check("t1_payload", 80'(br_svc_data_o.payload), 80'(32'hCAFE_0001));
    check("t1_ksvc", 80'(br_svc_data_o.ksvc), 80'(8'h12));
    check("t1_producer", 80'(br_svc_data_o.producer), 80'(16'h0101));

    // Fill to full and hold the router off
    repeat (30) step(100, 0);
    check("full_rx", 80'(br_svc_rx_o), 80'(1));
    check("full_no_ack", 80'(br_ack_o), 80'(0));
`ifdef BR_SVC_STATS_EN
    check("full_level", 80'(svc_level_o), 80'(BS));
`endif

    // Full with pops colliding with pending requests
    repeat (40) step(100, 30);
    // Drain, then pop pulses on empty
    repeat (40) step(30, 100);
    repeat (10) step(0, 100);
    check("empty_rx", 80'(br_svc_rx_o), 80'(0));
    // Interleaved push/pop across pointer wrap
    repeat (50) step(100, 100);

    // Random traffic mixes
    for (int p = 0; p < 6; p++) begin
      int rp;
      int pp;
      rp = int'($urandom_range(100));
      pp = int'($urandom_range(100));
      repeat (60) step(rp, pp);
    end

    // Reset with entries buffered and a request pending
    repeat (12) step(100, 0);
    reset_dut();
    repeat (40) step(100, 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_br_svc_buffer
`default_nettype wire
